// File: rtl/aes_pkg.sv
// Shared AES definitions: schedule constants, Rcon table, state encoding and
// the InvMixColumns column function reused by the decipher datapath.
package aes_pkg;

    localparam int NK     = 8;
    localparam int NR     = 14;
    localparam int NWORDS = 4 * (NR + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Only indices 1..7 occur for a 256-bit key schedule.
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int k = 0; k < 4; k++) begin
            a[k]  = col[31 - 8*k -: 8];
            x2    = gf_xtime(a[k]);
            x4    = gf_xtime(x2);
            x8    = gf_xtime(x4);
            m9[k] = x8 ^ a[k];
            mb[k] = x8 ^ x2 ^ a[k];
            md[k] = x8 ^ x4 ^ a[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box lookup.
// Latency: combinational, no registers.
// Backpressure: none, pure function of the input byte.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte.
    assign dout = SBOX_FLAT[11'd2047 - {din, 3'b000} -: 8];

endmodule

// File: rtl/aes256_key_expander.sv
// Iterative AES-256 key schedule into a 60-word file with a combinational round-key read port.
// Latency: 53 edges from accepted start to key_valid (8-word load, then one word per cycle).
// Backpressure: start is ignored while busy; AES_EQINV_KEY_EN selects InvMixColumns on keys 1..13.
module aes256_key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         key_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] round_key
);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        load, gen;
    logic [31:0] word_file [NWORDS];
    logic [31:0] prev_w, back_w, sbox_in, sub_w, temp_w;
    logic [5:0]  base;
    logic [31:0] rd_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        gen     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = 6'(NK);
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                gen = 1'b1;
                if (cnt_q == 6'(NWORDS - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == EXPAND);
    assign key_valid = (state_q == DONE);

    assign prev_w  = word_file[cnt_q - 6'd1];
    assign back_w  = word_file[cnt_q - 6'd8];
    assign sbox_in = (cnt_q[2:0] == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .din  (sbox_in[31 - 8*g -: 8]),
            .dout (sub_w[31 - 8*g -: 8])
        );
    end

    always_comb begin
        temp_w = prev_w;
        if (cnt_q[2:0] == 3'd0) begin
            temp_w = sub_w ^ {rcon(cnt_q[5:3]), 24'h000000};
        end else if (cnt_q[2:0] == 3'd4) begin
            temp_w = sub_w;
        end
    end

    // Word storage carries no reset; key_valid gates every read.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NK; k++) begin
                word_file[k] <= key[255 - 32*k -: 32];
            end
        end else if (gen) begin
            word_file[cnt_q] <= back_w ^ temp_w;
        end
    end

    assign base = {rk_idx, 2'b00};

    always_comb begin
        round_key = '0;
        rd_w      = '0;
        if (key_valid && (rk_idx != 4'd15)) begin
            for (int k = 0; k < 4; k++) begin
                rd_w = word_file[base + 6'(k)];
`ifdef AES_EQINV_KEY_EN
                if ((rk_idx != 4'd0) && (rk_idx != 4'(NR))) begin
                    rd_w = inv_mix_column(rd_w);
                end
`endif
                round_key[127 - 32*k -: 32] = rd_w;
            end
        end
    end

endmodule

// File: tb/tb_aes256_key_expander.sv
// Directed bench for the AES-256 key expander: reset, latency, ignored starts,
// restart from DONE, asynchronous abort and round-key reads against known vectors.
module tb_aes256_key_expander;

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K1_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K1_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] K1_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] K3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [31:0]  K3_W8   = 32'h9ba35411;
`ifdef AES_EQINV_KEY_EN
    localparam bit EQINV = 1'b1;
`else
    localparam bit EQINV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key = '0;
    logic         busy;
    logic         key_valid;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] round_key;

    int checks = 0;
    int errors = 0;
    int edges, busy_cycles, overlap;
    logic [127:0] rk;

    always #5 clk = ~clk;

    aes256_key_expander dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .key_valid (key_valid),
        .rk_idx    (rk_idx),
        .round_key (round_key)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] imc(input logic [31:0] w);
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [31:0] r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            acc = '0;
            for (int c = 0; c < 4; c++) begin
                acc = acc ^ gmul(w[31 - 8*c -: 8], coef[(c - row + 4) % 4]);
            end
            r[31 - 8*row -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_key(input logic [127:0] raw, input int idx);
        logic [127:0] r;
        r = raw;
        if (EQINV && idx >= 1 && idx <= 13) begin
            for (int k = 0; k < 4; k++) r[127 - 32*k -: 32] = imc(raw[127 - 32*k -: 32]);
        end
        return r;
    endfunction

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
        rk_idx = idx;
        #1;
        v = round_key;
    endtask

    // Pulses start, then counts edges until key_valid with a hard bound.
    task automatic run_expand(input logic [255:0] k, input bit inject,
                              output int n, output int nbusy, output int nboth);
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = ~k;
        n     = 1;
        nbusy = 0;
        nboth = 0;
        check("kv_low_after_start", 128'(key_valid), 128'd0);
        check("rk_zero_while_busy", round_key, 128'd0);
        while (!key_valid && n < 200) begin
            if (busy) nbusy++;
            if (busy && key_valid) nboth++;
            start = inject && (n == 5 || n == 30);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        if (busy && key_valid) nboth++;
    endtask

    initial begin
        #12;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_round_key", round_key, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Key 00..1f
        run_expand(K1, 1'b0, edges, busy_cycles, overlap);
        check("k1_edges", 128'(edges), 128'd53);
        check("k1_busy_cycles", 128'(busy_cycles), 128'd52);
        check("k1_overlap", 128'(overlap), 128'd0);
        check("k1_busy_done", 128'(busy), 128'd0);
        read_rk(4'd0, rk);  check("k1_rk0", rk, exp_key(K1_RK0, 0));
        read_rk(4'd1, rk);  check("k1_rk1", rk, exp_key(K1_RK1, 1));
        read_rk(4'd2, rk);  check("k1_rk2", rk, exp_key(K1_RK2, 2));
        read_rk(4'd14, rk); check("k1_rk14", rk, exp_key(K1_RK14, 14));
        read_rk(4'd15, rk); check("k1_rk15", rk, 128'd0);

        // Restart from DONE with the FIPS-197 AES-256 key
        rk_idx = 4'd14;
        run_expand(K3, 1'b0, edges, busy_cycles, overlap);
        check("k3_edges", 128'(edges), 128'd53);
        read_rk(4'd0, rk);  check("k3_rk0", rk, exp_key(K3_RK0, 0));
        read_rk(4'd2, rk);
        if (EQINV) check("k3_w8", 128'(rk[127:96]), 128'(imc(K3_W8)));
        else       check("k3_w8", 128'(rk[127:96]), 128'(K3_W8));
        read_rk(4'd14, rk); check("k3_rk14", rk, exp_key(K3_RK14, 14));

        // Starts mid-expansion must be ignored
        run_expand(K1, 1'b1, edges, busy_cycles, overlap);
        check("ign_edges", 128'(edges), 128'd53);
        check("ign_busy_cycles", 128'(busy_cycles), 128'd52);
        read_rk(4'd0, rk);  check("ign_rk0", rk, exp_key(K1_RK0, 0));
        read_rk(4'd1, rk);  check("ign_rk1", rk, exp_key(K1_RK1, 1));
        read_rk(4'd14, rk); check("ign_rk14", rk, exp_key(K1_RK14, 14));

        // Asynchronous reset during expansion
        key    = K3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check("abort_busy_before", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_key_valid", 128'(key_valid), 128'd0);
        check("abort_round_key", round_key, 128'd0);
        #1;
        rst_n = 1'b1;
        run_expand(K3, 1'b0, edges, busy_cycles, overlap);
        check("rerun_edges", 128'(edges), 128'd53);
        check("rerun_overlap", 128'(overlap), 128'd0);
        read_rk(4'd0, rk);  check("rerun_rk0", rk, exp_key(K3_RK0, 0));
        read_rk(4'd14, rk); check("rerun_rk14", rk, exp_key(K3_RK14, 14));
        read_rk(4'd15, rk); check("rerun_rk15", rk, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
